// File: rtl/dme_pkg.sv
// Shared types and constants for the DME receive-side status monitor.
package dme_pkg;

  localparam int unsigned DME_ID_W     = 4;
  localparam int unsigned DME_STATUS_W = 6;
  localparam int unsigned FLT_W        = 2;
  localparam int unsigned TMO_W        = 16;
  localparam int unsigned DB_CNT_W     = 8;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_WAIT_PWRGD = 2'd1,
    ST_RUN        = 2'd2,
    ST_FAULT      = 2'd3
  } dme_state_e;

  localparam logic [FLT_W-1:0] FLT_NONE       = 2'b00;
  localparam logic [FLT_W-1:0] FLT_TIMEOUT    = 2'b01;
  localparam logic [FLT_W-1:0] FLT_PWRGD_LOST = 2'b10;
  localparam logic [FLT_W-1:0] FLT_REMOVED    = 2'b11;

endpackage

// File: rtl/dme_debounce.sv
// Vector debouncer: the stable value follows the synchronized input only after
// DEBOUNCE_CYCLES consecutive identical samples.
module dme_debounce
  import dme_pkg::*;
#(
  parameter int unsigned WIDTH           = 1,
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] stable
);

  localparam logic [DB_CNT_W-1:0] CNT_MAX = DB_CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0]    cand;
  logic [DB_CNT_W-1:0] cnt;

  // Any difference restarts the run; a full run promotes the candidate.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cand   <= '0;
      cnt    <= '0;
      stable <= '0;
    end else if (din != cand) begin
      cand <= din;
      cnt  <= '0;
    end else if (cnt == CNT_MAX) begin
      stable <= cand;
    end else begin
      cnt <= cnt + DB_CNT_W'(1);
    end
  end

endmodule

// File: rtl/dme_status_monitor.sv
// Synchronizes, debounces and sequences the DME daughter-module return signals,
// reporting readiness, status changes and power faults to the register block.
module dme_status_monitor
  import dme_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned PWRGD_TIMEOUT   = 1000
) (
  input  logic                    CLK_33M,
  input  logic                    Reset,
  input  logic                    PWRGD_PS_PWROK_3V3,
  input  logic                    DME_PWRGD,
  input  logic                    DME_Absent,
  input  logic [DME_ID_W-1:0]     DMEID,
  input  logic [DME_STATUS_W-1:0] DMEStatus,
  input  logic                    StatusAck,
  output logic                    DMEPresent,
  output logic                    DMEReady,
  output logic [DME_ID_W-1:0]     DMEIDLatched,
  output logic [DME_STATUS_W-1:0] DMEStatusStable,
  output logic                    StatusChanged,
  output logic                    DMEFault,
  output logic [FLT_W-1:0]        FaultCode
);

  localparam int unsigned SYNC_W = 3 + DME_ID_W + DME_STATUS_W;
  localparam logic [TMO_W-1:0] TMO_MAX = TMO_W'(PWRGD_TIMEOUT - 1);

  logic [SYNC_W-1:0]       sync1, sync2;
  logic                    ps_ok_s, pwrgd_s, absent_s;
  logic [DME_ID_W-1:0]     id_s;
  logic [DME_STATUS_W-1:0] status_s;
  logic                    absent_stable;
  logic [DME_STATUS_W-1:0] status_prev;
  logic [TMO_W-1:0]        tmo_cnt;
  dme_state_e              state, state_nxt;
  logic [FLT_W-1:0]        flt_nxt;

  // Two-flop synchronizer for every asynchronous input.
  always_ff @(posedge CLK_33M or posedge Reset) begin
    if (Reset) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= {PWRGD_PS_PWROK_3V3, DME_PWRGD, DME_Absent, DMEID, DMEStatus};
      sync2 <= sync1;
    end
  end

  assign {ps_ok_s, pwrgd_s, absent_s, id_s, status_s} = sync2;

  dme_debounce #(
    .WIDTH          (1),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_db_absent (
    .clk   (CLK_33M),
    .rst   (Reset),
    .din   (absent_s),
    .stable(absent_stable)
  );

  dme_debounce #(
    .WIDTH          (DME_STATUS_W),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_db_status (
    .clk   (CLK_33M),
    .rst   (Reset),
    .din   (status_s),
    .stable(DMEStatusStable)
  );

  // Next state: PS OK loss overrides everything, removal beats PWRGD events.
  always_comb begin
    state_nxt = state;
    flt_nxt   = FLT_NONE;
    if (!ps_ok_s) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (DMEPresent) state_nxt = ST_WAIT_PWRGD;
        end
        ST_WAIT_PWRGD: begin
          if (!DMEPresent) begin
            state_nxt = ST_FAULT;
            flt_nxt   = FLT_REMOVED;
          end else if (pwrgd_s) begin
            state_nxt = ST_RUN;
          end else if (tmo_cnt == TMO_MAX) begin
            state_nxt = ST_FAULT;
            flt_nxt   = FLT_TIMEOUT;
          end
        end
        ST_RUN: begin
          if (!DMEPresent) begin
            state_nxt = ST_FAULT;
            flt_nxt   = FLT_REMOVED;
          end else if (!pwrgd_s) begin
            state_nxt = ST_FAULT;
            flt_nxt   = FLT_PWRGD_LOST;
          end
        end
        ST_FAULT: state_nxt = ST_FAULT;
        default:  state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK_33M or posedge Reset) begin
    if (Reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Timeout counter reads 0 on the first WAIT_PWRGD cycle.
  always_ff @(posedge CLK_33M or posedge Reset) begin
    if (Reset) begin
      tmo_cnt <= '0;
    end else if (state != ST_WAIT_PWRGD) begin
      tmo_cnt <= '0;
    end else begin
      tmo_cnt <= tmo_cnt + TMO_W'(1);
    end
  end

  always_ff @(posedge CLK_33M or posedge Reset) begin
    if (Reset) begin
      DMEPresent   <= 1'b0;
      DMEReady     <= 1'b0;
      DMEIDLatched <= '0;
    end else begin
      DMEPresent <= ~absent_stable;
      DMEReady   <= (state_nxt == ST_RUN);
      if (state == ST_WAIT_PWRGD && state_nxt == ST_RUN) DMEIDLatched <= id_s;
    end
  end

  // Fault is captured on entry; an ack inside FAULT is ignored.
  always_ff @(posedge CLK_33M or posedge Reset) begin
    if (Reset) begin
      DMEFault  <= 1'b0;
      FaultCode <= FLT_NONE;
    end else if (state_nxt == ST_FAULT && state != ST_FAULT) begin
      DMEFault  <= 1'b1;
      FaultCode <= flt_nxt;
    end else if (StatusAck && state != ST_FAULT) begin
      DMEFault  <= 1'b0;
      FaultCode <= FLT_NONE;
    end
  end

  // Sticky change flag; a new change wins over a simultaneous ack.
  always_ff @(posedge CLK_33M or posedge Reset) begin
    if (Reset) begin
      status_prev   <= '0;
      StatusChanged <= 1'b0;
    end else begin
      status_prev <= DMEStatusStable;
      if (state == ST_RUN && DMEStatusStable != status_prev) begin
        StatusChanged <= 1'b1;
      end else if (StatusAck) begin
        StatusChanged <= 1'b0;
      end
    end
  end

endmodule
